cmd_arbiter: RTL
================

Name: cmd_arbiter

Overview:
Schedules and shares the single CMD-line command path between three command sources: software command register, auto-CMD23 (block count) and auto-CMD12 (stop transmission).
- Grants one requester at a time by fixed priority.
- Drives CMD_master's new_cmd/cmd_index/cmd_arg and waits for completion or error.
- Returns the response status and error to the granted requester.
- Runs a watchdog that aborts a hung command via CMD_master's physical_inactive.
- Sits between the host register/DAT control logic and CMD_master, in the CLK_host domain.

Parameters:
WD_W, 16, watchdog counter width.
WD_LIMIT, 16'hFFFF, CLK_host cycles allowed from grant to completion before abort.

Ports:
CLK_host  input  1  host clock; all logic on rising edge.
reset  input  1  synchronous, active-high.
req  input  3  level requests; bit0 software, bit1 auto-CMD23, bit2 auto-CMD12.
req_index  input  18  per-requester command index; requester i uses bits [6i+5:6i].
req_arg  input  96  per-requester argument; requester i uses bits [32i+31:32i].
done  output  3  one-hot, one-cycle completion pulse to the granted requester.
err  output  1  valid while done!=0; 1 = command failed.
err_code  output  2  valid with done; 00 ok, 01 CMD timeout, 10 watchdog abort.
rsp_status  output  32  captured response status; stable from the done cycle until the next done.
grant_id  output  2  index of the current/last granted requester.
arb_busy  output  1  high in any state other than IDLE.
new_cmd  output  1  to CMD_master.
cmd_index  output  6  to CMD_master; latched at grant.
cmd_arg  output  32  to CMD_master; latched at grant.
cmd_abort  output  1  to CMD_master physical_inactive; one-cycle pulse.
cmd_busy  input  1  from CMD_master.
cmd_complete  input  1  from CMD_master; one-cycle pulse.
timeout_error  input  1  from CMD_master; one-cycle pulse.
response_status  input  32  from CMD_master; valid in the cmd_complete cycle.

Behaviour:
Reset values:
- Synchronous reset forces IDLE.
- All outputs 0: done, err, err_code, rsp_status, grant_id, arb_busy, new_cmd, cmd_index, cmd_arg, cmd_abort.
- Watchdog counter cleared.
- Reset mid-command drops the command silently: no done pulse, no abort pulse.

IDLE:
- If req!=0, grant the highest priority: bit2 > bit1 > bit0.
- At the same edge, latch grant_id, cmd_index and cmd_arg from that requester's slice, clear the watchdog, and go to ISSUE.

ISSUE:
- new_cmd=1 (registered, so first asserted the cycle after grant).
- Hold new_cmd until cmd_busy==1 is sampled, then deassert and go to WAIT_DONE.

WAIT_DONE:
- Wait for cmd_complete or timeout_error.
- cmd_complete: capture response_status into rsp_status, err=0, err_code=00.
- timeout_error: err=1, err_code=01, rsp_status unchanged. timeout_error wins if it coincides with cmd_complete.
- Either event goes to RESPOND.

Watchdog:
- Increments every cycle in ISSUE and WAIT_DONE.
- When the count reaches WD_LIMIT with no completion/error in that cycle: pulse cmd_abort for 1 cycle, err=1, err_code=10, go to RESPOND.
- A completion/error in the same cycle as expiry takes precedence over the watchdog.

RESPOND:
- done[grant_id]=1 for exactly one cycle, with err/err_code valid.
- Next state IDLE.
- The requester must drop req on the cycle it sees done. A still-asserted req in IDLE is treated as a new command.

Ordering and timing rules:
- No preemption: a higher-priority request arriving mid-command waits for IDLE.
- req changes or slice changes after grant have no effect on the in-flight command.
- cmd_index/cmd_arg hold their latched value until the next grant.
- Minimum grant-to-done latency: grant edge → ISSUE → CMD_master SETUP/ACK/response cycles → RESPOND. arb_busy is high throughout.
- Back-to-back requests: at least one IDLE cycle between done and the next new_cmd.
- Watchdog does not wrap: it saturates at WD_LIMIT.

Test Plan:
1. After reset, only req=3'b001, index 6'd17, arg 32'h0000_0200; model CMD_master returns cmd_complete with response_status 32'h0000_0900 → new_cmd asserted with cmd_index=17 and cmd_arg=0x200; done=3'b001 for 1 cycle with err=0, err_code=00, rsp_status=0x0000_0900.
2. req=3'b111 raised in the same cycle → grant order CMD12 (bit2), then CMD23 (bit1), then software (bit0), each requester dropping req on its done; exactly three done pulses, each one-hot, in that order.
3. Model asserts timeout_error and cmd_complete in the same cycle → done pulse with err=1, err_code=01; rsp_status keeps its previous value.
4. WD_LIMIT=8, model never completes → exactly one cmd_abort pulse 8 cycles after grant; done with err=1, err_code=10; arb_busy=0 the following cycle.
5. Reset asserted while in WAIT_DONE → next cycle all outputs 0 and state IDLE; no done pulse; a new req is granted normally afterwards.
6. req bit0 held high through done → a second command is issued after one IDLE cycle (new_cmd reasserts); bit2 raised during WAIT_DONE is not serviced until the current done completes.

Source files
------------

// File: rtl/cmd_arbiter.sv
// -----------------------------------------------------------------------------
// cmd_arbiter
//   Shares the single CMD-line command path (CMD_master) between three command
//   sources: software command register (req[0]), auto-CMD23 (req[1]) and
//   auto-CMD12 (req[2]). Grants by fixed priority (bit2 > bit1 > bit0), issues
//   the granted command, waits for completion or error, and returns a one-cycle
//   done pulse with status to the granted requester. A watchdog aborts a hung
//   command through CMD_master's physical_inactive input.
//
// Ports
//   CLK_host        host clock, rising edge
//   reset           synchronous, active-high
//   req[2:0]        level requests (bit0 sw, bit1 CMD23, bit2 CMD12)
//   req_index[17:0] per-requester command index, slice [6i+5:6i]
//   req_arg[95:0]   per-requester argument, slice [32i+31:32i]
//   done[2:0]       one-hot completion pulse to the granted requester
//   err, err_code   result, valid with done (00 ok, 01 CMD timeout, 10 abort)
//   rsp_status      captured response status, held until the next done
//   grant_id        current/last granted requester
//   arb_busy        high whenever the arbiter is not IDLE
//   new_cmd, cmd_index, cmd_arg, cmd_abort   to CMD_master
//   cmd_busy, cmd_complete, timeout_error, response_status   from CMD_master
// -----------------------------------------------------------------------------
module cmd_arbiter #(
  parameter int             WD_W     = 16,
  parameter logic [WD_W-1:0] WD_LIMIT = 16'hFFFF
) (
  input  logic        CLK_host,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [17:0] req_index,
  input  logic [95:0] req_arg,
  output logic [2:0]  done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [31:0] rsp_status,
  output logic [1:0]  grant_id,
  output logic        arb_busy,
  output logic        new_cmd,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic        cmd_abort,
  input  logic        cmd_busy,
  input  logic        cmd_complete,
  input  logic        timeout_error,
  input  logic [31:0] response_status
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    RESPOND   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [WD_W-1:0] wd_q, wd_d, wd_inc_s;
  logic [2:0]      done_q, done_d;
  logic            err_q, err_d;
  logic [1:0]      err_code_q, err_code_d;
  logic [31:0]     rsp_status_q, rsp_status_d;
  logic [1:0]      grant_id_q, grant_id_d;
  logic            arb_busy_q, arb_busy_d;
  logic            new_cmd_q, new_cmd_d;
  logic [5:0]      cmd_index_q, cmd_index_d;
  logic [31:0]     cmd_arg_q, cmd_arg_d;
  logic            cmd_abort_q, cmd_abort_d;

  // Decoded events of the current cycle, shared by next-state and output logic
  logic            grant_s;
  logic [1:0]      grant_sel_s;
  logic            rsp_ok_s;
  logic            rsp_to_s;
  logic            wd_abort_s;

  // State and watchdog register
  always_ff @(posedge CLK_host) begin
    if (reset) begin
      state_q <= IDLE;
      wd_q    <= {WD_W{1'b0}};
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
    end
  end

  // Next-state logic, priority select and watchdog
  always_comb begin
    state_d     = state_q;
    wd_d        = wd_q;
    grant_s     = 1'b0;
    rsp_ok_s    = 1'b0;
    rsp_to_s    = 1'b0;
    wd_abort_s  = 1'b0;

    if (req[2]) begin
      grant_sel_s = 2'd2;
    end else if (req[1]) begin
      grant_sel_s = 2'd1;
    end else begin
      grant_sel_s = 2'd0;
    end

    // Saturating increment: the count never wraps past WD_LIMIT
    if (wd_q == WD_LIMIT) begin
      wd_inc_s = wd_q;
    end else begin
      wd_inc_s = wd_q + {{(WD_W-1){1'b0}}, 1'b1};
    end

    case (state_q)
      IDLE: begin
        if (req != 3'b000) begin
          grant_s = 1'b1;
          wd_d    = {WD_W{1'b0}};
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        wd_d = wd_inc_s;
        if (wd_inc_s == WD_LIMIT) begin
          wd_abort_s = 1'b1;
          state_d    = RESPOND;
        end else if (cmd_busy) begin
          state_d = WAIT_DONE;
        end else begin
          state_d = ISSUE;
        end
      end
      WAIT_DONE: begin
        wd_d = wd_inc_s;
        // A real completion/error in the expiry cycle beats the watchdog;
        // a timeout beats a coincident completion.
        if (timeout_error) begin
          rsp_to_s = 1'b1;
          state_d  = RESPOND;
        end else if (cmd_complete) begin
          rsp_ok_s = 1'b1;
          state_d  = RESPOND;
        end else if (wd_inc_s == WD_LIMIT) begin
          wd_abort_s = 1'b1;
          state_d    = RESPOND;
        end else begin
          state_d = WAIT_DONE;
        end
      end
      RESPOND: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output next values; every output is registered off the next state
  always_comb begin
    done_d       = 3'b000;
    err_d        = 1'b0;
    err_code_d   = 2'b00;
    rsp_status_d = rsp_status_q;
    grant_id_d   = grant_id_q;
    cmd_index_d  = cmd_index_q;
    cmd_arg_d    = cmd_arg_q;

    if (grant_s) begin
      grant_id_d = grant_sel_s;
      case (grant_sel_s)
        2'd2: begin
          cmd_index_d = req_index[17:12];
          cmd_arg_d   = req_arg[95:64];
        end
        2'd1: begin
          cmd_index_d = req_index[11:6];
          cmd_arg_d   = req_arg[63:32];
        end
        default: begin
          cmd_index_d = req_index[5:0];
          cmd_arg_d   = req_arg[31:0];
        end
      endcase
    end else begin
      grant_id_d = grant_id_q;
    end

    if (state_d == RESPOND) begin
      case (grant_id_q)
        2'd0:    done_d = 3'b001;
        2'd1:    done_d = 3'b010;
        2'd2:    done_d = 3'b100;
        default: done_d = 3'b000;
      endcase
    end else begin
      done_d = 3'b000;
    end

    if (rsp_to_s) begin
      err_d      = 1'b1;
      err_code_d = 2'b01;
    end else if (wd_abort_s) begin
      err_d      = 1'b1;
      err_code_d = 2'b10;
    end else begin
      err_d      = 1'b0;
      err_code_d = 2'b00;
    end

    if (rsp_ok_s) begin
      rsp_status_d = response_status;
    end else begin
      rsp_status_d = rsp_status_q;
    end

    new_cmd_d   = (state_d == ISSUE);
    arb_busy_d  = (state_d != IDLE);
    cmd_abort_d = wd_abort_s;
  end

  // Output registers
  always_ff @(posedge CLK_host) begin
    if (reset) begin
      done_q       <= 3'b000;
      err_q        <= 1'b0;
      err_code_q   <= 2'b00;
      rsp_status_q <= 32'h0000_0000;
      grant_id_q   <= 2'd0;
      arb_busy_q   <= 1'b0;
      new_cmd_q    <= 1'b0;
      cmd_index_q  <= 6'd0;
      cmd_arg_q    <= 32'h0000_0000;
      cmd_abort_q  <= 1'b0;
    end else begin
      done_q       <= done_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
      rsp_status_q <= rsp_status_d;
      grant_id_q   <= grant_id_d;
      arb_busy_q   <= arb_busy_d;
      new_cmd_q    <= new_cmd_d;
      cmd_index_q  <= cmd_index_d;
      cmd_arg_q    <= cmd_arg_d;
      cmd_abort_q  <= cmd_abort_d;
    end
  end

  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = err_code_q;
  assign rsp_status = rsp_status_q;
  assign grant_id   = grant_id_q;
  assign arb_busy   = arb_busy_q;
  assign new_cmd    = new_cmd_q;
  assign cmd_index  = cmd_index_q;
  assign cmd_arg    = cmd_arg_q;
  assign cmd_abort  = cmd_abort_q;

endmodule
